uart_cmd_streamer: RTL and testbench
====================================

# uart_cmd_streamer

Command/stream controller on the byte side of the UART. It consumes received bytes (one-cycle `rx_valid` pulses from the UART receiver) and drives the UART transmitter's byte-ready strobe. Depending on the received command, it answers a ping, loads the frame RAM from the host, or dumps the frame RAM back to the host. It is the only client of both UART byte ports and of the frame-RAM port.

## Interface
- `ADDR_W`, 12: frame-RAM address width.
- `DUMP_LEN`, 4096: number of bytes per load or dump, starting at address 0. Range 1..2^ADDR_W.
- `BYTE_GAP`, 520: minimum clocks between consecutive `tx_strobe` pulses. Must be ≥ 500 for the UART's 10-bit × 50-clock frame; simulation may use ≥ 4.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  received byte; valid only with `rx_valid`.
- `rx_valid`  in  1  one-cycle pulse, byte received.
- `tx_data`  out  8  byte to transmit; held stable from the strobe until the next strobe.
- `tx_strobe`  out  1  one-cycle pulse that hands `tx_data` to the transmitter.
- `ram_addr`  out  ADDR_W  frame-RAM address.
- `ram_rd_data`  in  8  frame-RAM read data. Synchronous read: valid on the cycle after `ram_addr`.
- `ram_wr_en`  out  1  one-cycle write enable.
- `ram_wr_data`  out  8  write data.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Commands are decoded only in IDLE:
  - 0x50 'P': reply 0x70.
  - 0x52 'R': dump.
  - 0x57 'W': load.
  - Any other byte: reply 0x3F.
- States:
  - IDLE: wait for `rx_valid`.
  - REPLY: hold the reply byte until the TX gap expires, strobe it, then go to IDLE.
  - LOAD: each `rx_valid` writes `rx_data` to `ram_addr`, then `ram_addr` increments. After the `DUMP_LEN`th write, `ram_addr` returns to 0 and the reply byte 0x77 is sent through REPLY.
  - DUMP_WAIT: one cycle for the RAM read latency, then go to DUMP_SEND.
  - DUMP_SEND: when the gap has expired, strobe with `tx_data` = `ram_rd_data`. If `ram_addr` = `DUMP_LEN`-1, set `ram_addr` to 0 and go to IDLE. Otherwise increment `ram_addr` and go to DUMP_WAIT.
- TX gap counter:
  - Loaded with `BYTE_GAP`-1 on every strobe; decrements to 0 and saturates.
  - A strobe is allowed only when the counter is 0.
  - The counter runs independently of state.
- `rx_valid` in REPLY, DUMP_WAIT or DUMP_SEND is ignored: no queuing and no effect.
- Address arithmetic is ADDR_W-bit unsigned. When `DUMP_LEN` = 2^ADDR_W, the terminal increment wraps to 0, which matches the required return to 0.
- `tx_strobe` is never high on two consecutive cycles. The transmitter stalls while its strobe is high, so a multi-cycle strobe is a defect.

## Timing
- Reset values:
  - `tx_strobe` = 0, `tx_data` = 0x00
  - `ram_addr` = 0, `ram_wr_en` = 0, `ram_wr_data` = 0x00
  - `busy` = 0, state = IDLE
  - gap counter = `BYTE_GAP`-1, so the first strobe comes no earlier than `BYTE_GAP` clocks after reset release.
- Reset asserted mid-operation: all of the above apply immediately (asynchronously). No partial reply or partial dump resumes.
- Ping: `rx_valid` at cycle t with the gap expired → `tx_strobe` at t+1. With the gap not expired → strobe on the first cycle the counter is 0.
- Load: `rx_valid` at t → `ram_wr_en` high at t+1 with `ram_addr`/`ram_wr_data` valid; the address increments at t+2.
- Dump: 'R' at t → `ram_addr` = 0 at t+1 (DUMP_WAIT), first strobe at t+2 if the gap has expired. Later strobes come exactly `BYTE_GAP` cycles apart.
- `busy` rises the cycle after the command `rx_valid`. It falls the cycle after the final strobe, or after the final write plus reply strobe.

## Test plan
Run with `BYTE_GAP`=8 and `DUMP_LEN`=4 unless stated.

- Ping: after reset, wait 8 clocks, then pulse 0x50 → exactly one `tx_strobe` one cycle later with `tx_data`=0x70; `busy` back to 0 next cycle.
- Unknown command: pulse 0x41, then immediately pulse 0x50 while in REPLY → one strobe with 0x3F; the 0x50 is dropped; no second strobe in the next 20 clocks.
- Load: 0x57 followed by bytes 0x11, 0x22, 0x33, 0x44 → RAM writes (0,0x11), (1,0x22), (2,0x33), (3,0x44), each a one-cycle `ram_wr_en`; then a strobe with 0x77; `ram_addr` ends at 0.
- Dump: after the load, 0x52 → strobes with 0x11, 0x22, 0x33, 0x44 spaced exactly 8 clocks apart; no fifth strobe; IDLE afterwards.
- Gap enforcement: two pings 3 clocks apart, both in IDLE → the second strobe comes 8 clocks after the first, never earlier; `tx_strobe` is never high two cycles in a row.
- Reset mid-dump: assert `rst_n` low after the second dump strobe → outputs go to reset values immediately; after release, no strobe within the first 8 clocks and no resumed dump.

Source files
------------

// File: rtl/uart_cmd_streamer.sv
// Byte-side command controller for the UART: answers pings, loads the frame RAM from the
// host and dumps it back, pacing every transmitted byte with a minimum strobe gap.
module uart_cmd_streamer #(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned DUMP_LEN = 4096,
  parameter int unsigned BYTE_GAP = 520
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_strobe,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [7:0]        ram_rd_data,
  output logic              ram_wr_en,
  output logic [7:0]        ram_wr_data,
  output logic              busy
);

  localparam int unsigned       GapW     = (BYTE_GAP > 1) ? $clog2(BYTE_GAP) : 1;
  localparam logic [GapW-1:0]   GapLoad  = GapW'(BYTE_GAP - 1);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DUMP_LEN - 1);

  localparam logic [7:0] CmdPing   = 8'h50;
  localparam logic [7:0] CmdDump   = 8'h52;
  localparam logic [7:0] CmdLoad   = 8'h57;
  localparam logic [7:0] RplPing   = 8'h70;
  localparam logic [7:0] RplLoaded = 8'h77;
  localparam logic [7:0] RplError  = 8'h3F;

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StReply    = 3'd1;
  localparam logic [2:0] StLoad     = 3'd2;
  localparam logic [2:0] StDumpWait = 3'd3;
  localparam logic [2:0] StDumpSend = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [7:0]        reply_q, reply_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_en_q, wr_en_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic              fire;
  logic [7:0]        tx_src;

  always_comb begin
    state_d   = state_q;
    reply_d   = reply_q;
    addr_d    = addr_q;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    fire      = 1'b0;
    tx_src    = reply_q;

    case (state_q)
      StIdle: begin
        if (rx_valid) begin
          addr_d = '0;
          case (rx_data)
            CmdPing: begin
              reply_d = RplPing;
              state_d = StReply;
            end
            CmdDump: state_d = StDumpWait;
            CmdLoad: state_d = StLoad;
            default: begin
              reply_d = RplError;
              state_d = StReply;
            end
          endcase
        end
      end
      StReply: begin
        if (gap_q == '0) begin
          fire    = 1'b1;
          state_d = StIdle;
        end
      end
      StLoad: begin
        // Address advances the cycle after each write so the write sees the old address.
        if (wr_en_q) begin
          if (addr_q == LastAddr) begin
            addr_d  = '0;
            reply_d = RplLoaded;
            state_d = StReply;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
        if (rx_valid && (state_d == StLoad)) begin
          wr_en_d   = 1'b1;
          wr_data_d = rx_data;
        end
      end
      StDumpWait: state_d = StDumpSend;
      StDumpSend: begin
        if (gap_q == '0) begin
          fire   = 1'b1;
          tx_src = ram_rd_data;
          if (addr_q == LastAddr) begin
            addr_d  = '0;
            state_d = StIdle;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = StDumpWait;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Output byte is presented combinationally with the strobe, then held in tx_data_q.
    tx_data_d = fire ? tx_src : tx_data_q;
    if (fire) begin
      gap_d = GapLoad;
    end else if (gap_q != '0) begin
      gap_d = gap_q - GapW'(1);
    end else begin
      gap_d = gap_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      reply_q   <= 8'h00;
      tx_data_q <= 8'h00;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= 8'h00;
      gap_q     <= GapLoad;
    end else begin
      state_q   <= state_d;
      reply_q   <= reply_d;
      tx_data_q <= tx_data_d;
      addr_q    <= addr_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      gap_q     <= gap_d;
    end
  end

  assign tx_strobe   = fire;
  assign tx_data     = tx_data_d;
  assign ram_addr    = addr_q;
  assign ram_wr_en   = wr_en_q;
  assign ram_wr_data = wr_data_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_uart_cmd_streamer.sv
// Bench for uart_cmd_streamer: command table, directed load/dump/reset sequences and a
// randomized run checked against a transaction-level model of strobe timing and RAM contents.
module tb_uart_cmd_streamer;

  localparam int unsigned AW = 4;
  localparam int unsigned DL = 4;
  localparam int unsigned G  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic [7:0]    tx_data;
  logic          tx_strobe;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_rd_data;
  logic          ram_wr_en;
  logic [7:0]    ram_wr_data;
  logic          busy;

  always #5 clk = ~clk;

  uart_cmd_streamer #(
    .ADDR_W  (AW),
    .DUMP_LEN(DL),
    .BYTE_GAP(G)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_data    (tx_data),
    .tx_strobe  (tx_strobe),
    .ram_addr   (ram_addr),
    .ram_rd_data(ram_rd_data),
    .ram_wr_en  (ram_wr_en),
    .ram_wr_data(ram_wr_data),
    .busy       (busy)
  );

  // Frame RAM with one-cycle synchronous read.
  logic [7:0] mem [16];
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_addr] <= ram_wr_data;
    ram_rd_data <= mem[ram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int cyc; logic [7:0] data;} strobe_t;
  typedef struct {int cyc; logic [AW-1:0] addr; logic [7:0] data;} wr_t;
  typedef struct {logic [7:0] cmd; logic [7:0] exp; logic junk_en; logic [7:0] junk; logic quiet;} vec_t;

  strobe_t    got_s[$], exp_s[$];
  wr_t        got_w[$], exp_w[$];
  int         total = 0;
  int         bad = 0;
  int         last_s = 0;
  logic [7:0] model_mem [DL];
  vec_t       vecs [8];

  initial begin : monitor
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_strobe) begin
        got_s.push_back('{cyc, tx_data});
        total++;
        if (prev) begin
          bad++;
          $display("FAIL back_to_back_strobe cyc=%0d: got=1 need=0", cyc);
        end
      end
      if (ram_wr_en) got_w.push_back('{cyc, ram_addr, ram_wr_data});
      prev = tx_strobe;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got=timeout need=finish");
    $fatal(1, "bench did not terminate");
  end

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d: got=%0h need=%0h", name, cyc, got, exp);
    end
  endtask

  task automatic check_strobes(input string name);
    int n;
    total++;
    if (got_s.size() != exp_s.size()) begin
      bad++;
      $display("FAIL %s strobe_count: got=%0d need=%0d", name, got_s.size(), exp_s.size());
    end
    n = (got_s.size() < exp_s.size()) ? got_s.size() : exp_s.size();
    for (int i = 0; i < n; i++) begin
      total++;
      if (got_s[i].cyc != exp_s[i].cyc || got_s[i].data !== exp_s[i].data) begin
        bad++;
        $display("FAIL %s strobe%0d: got cyc=%0d data=%02h need cyc=%0d data=%02h", name, i,
                 got_s[i].cyc, got_s[i].data, exp_s[i].cyc, exp_s[i].data);
      end
    end
    got_s.delete();
    exp_s.delete();
  endtask

  task automatic check_writes(input string name);
    int n;
    total++;
    if (got_w.size() != exp_w.size()) begin
      bad++;
      $display("FAIL %s write_count: got=%0d need=%0d", name, got_w.size(), exp_w.size());
    end
    n = (got_w.size() < exp_w.size()) ? got_w.size() : exp_w.size();
    for (int i = 0; i < n; i++) begin
      total++;
      if (got_w[i].cyc != exp_w[i].cyc || got_w[i].addr !== exp_w[i].addr ||
          got_w[i].data !== exp_w[i].data) begin
        bad++;
        $display("FAIL %s write%0d: got cyc=%0d a=%0h d=%02h need cyc=%0d a=%0h d=%02h", name,
                 i, got_w[i].cyc, got_w[i].addr, got_w[i].data, exp_w[i].cyc, exp_w[i].addr,
                 exp_w[i].data);
      end
    end
    got_w.delete();
    exp_w.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, output int t);
    @(posedge clk);
    #1;
    rx_data  = b;
    rx_valid = 1'b1;
    t        = cyc;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  // Advance to the falling edge of cycle c (bounded).
  task automatic goto_neg(input int c);
    for (int n = 0; n < 5000; n++) begin
      @(negedge clk);
      if (cyc >= c) break;
    end
  endtask

  task automatic single_cmd(input logic [7:0] b, input logic [7:0] exp, input logic junk_en,
                            input logic [7:0] junk);
    int t, e, tj;
    send_byte(b, t);
    e = imax(t + 1, last_s + G);
    exp_s.push_back('{e, exp});
    last_s = e;
    goto_neg(t + 1);
    chk("single_busy_rise", busy, 1);
    if (junk_en && (cyc + 2 <= e)) send_byte(junk, tj);
    goto_neg(e + 1);
    chk("single_busy_fall", busy, 0);
    check_strobes("single");
  endtask

  task automatic load_cmd(input logic [31:0] word);
    int t, ti, e;
    send_byte(8'h57, t);
    goto_neg(t + 1);
    chk("load_busy_rise", busy, 1);
    ti = t;
    for (int i = 0; i < int'(DL); i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      send_byte(word[8*i +: 8], ti);
      exp_w.push_back('{ti + 1, AW'(i), word[8*i +: 8]});
      model_mem[i] = word[8*i +: 8];
    end
    e = imax(ti + 2, last_s + G);
    exp_s.push_back('{e, 8'h77});
    last_s = e;
    goto_neg(e + 1);
    chk("load_busy_fall", busy, 0);
    chk("load_addr_end", ram_addr, 0);
    check_writes("load");
    check_strobes("load_reply");
  endtask

  task automatic dump_cmd();
    int t, e0, elast, tj;
    send_byte(8'h52, t);
    e0 = imax(t + 2, last_s + G);
    for (int i = 0; i < int'(DL); i++) exp_s.push_back('{e0 + i * int'(G), model_mem[i]});
    elast  = e0 + (int'(DL) - 1) * int'(G);
    last_s = elast;
    goto_neg(t + 1);
    chk("dump_busy_rise", busy, 1);
    chk("dump_addr_start", ram_addr, 0);
    for (int k = 0; k < 3; k++) begin
      if (cyc + 2 <= elast) send_byte(8'($urandom), tj);
    end
    goto_neg(elast + 1);
    chk("dump_busy_fall", busy, 0);
    chk("dump_addr_end", ram_addr, 0);
    repeat (12) @(posedge clk);
    check_strobes("dump");
  endtask

  task automatic check_reset_values(input string name);
    chk({name, "_tx_strobe"}, tx_strobe, 0);
    chk({name, "_tx_data"}, tx_data, 0);
    chk({name, "_ram_addr"}, ram_addr, 0);
    chk({name, "_ram_wr_en"}, ram_wr_en, 0);
    chk({name, "_ram_wr_data"}, ram_wr_data, 0);
    chk({name, "_busy"}, busy, 0);
  endtask

  initial begin : main
    int t, t2, e, e0, e1;
    logic [7:0] b;

    vecs[0] = '{8'h50, 8'h70, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{8'h41, 8'h3F, 1'b1, 8'h50, 1'b1};
    vecs[2] = '{8'h00, 8'h3F, 1'b0, 8'h00, 1'b0};
    vecs[3] = '{8'hFF, 8'h3F, 1'b1, 8'h57, 1'b0};
    vecs[4] = '{8'h70, 8'h3F, 1'b0, 8'h00, 1'b0};
    vecs[5] = '{8'h51, 8'h3F, 1'b1, 8'h52, 1'b1};
    vecs[6] = '{8'h4F, 8'h3F, 1'b0, 8'h00, 1'b0};
    vecs[7] = '{8'h50, 8'h70, 1'b1, 8'h41, 1'b0};

    #12;
    check_reset_values("reset");
    @(negedge clk);
    rst_n  = 1'b1;
    last_s = cyc - 1;
    repeat (8) @(posedge clk);

    for (int i = 0; i < 8; i++) begin
      single_cmd(vecs[i].cmd, vecs[i].exp, vecs[i].junk_en, vecs[i].junk);
      if (vecs[i].quiet) begin
        repeat (20) @(posedge clk);
        check_strobes("quiet_after_reply");
      end
    end

    // Two pings three cycles apart: the second must wait out the full gap.
    repeat (10) @(posedge clk);
    send_byte(8'h50, t);
    e = imax(t + 1, last_s + G);
    exp_s.push_back('{e, 8'h70});
    last_s = e;
    goto_neg(t + 2);
    send_byte(8'h50, t2);
    e = imax(t2 + 1, last_s + G);
    exp_s.push_back('{e, 8'h70});
    last_s = e;
    goto_neg(e + 1);
    chk("gap_busy_fall", busy, 0);
    check_strobes("gap_pair");

    load_cmd(32'h4433_2211);
    dump_cmd();

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 10)) @(posedge clk);
      case ($urandom_range(0, 3))
        0: begin
          b = 8'($urandom);
          if (b == 8'h52 || b == 8'h57) b = 8'h50;
          single_cmd(b, (b == 8'h50) ? 8'h70 : 8'h3F, 1'($urandom), 8'($urandom));
        end
        1: single_cmd(8'h50, 8'h70, 1'($urandom), 8'($urandom));
        2: load_cmd($urandom);
        default: dump_cmd();
      endcase
    end

    // Reset in the middle of a dump, just after the second byte goes out.
    load_cmd(32'hA5C3_5A3C);
    send_byte(8'h52, t);
    e0 = imax(t + 2, last_s + G);
    e1 = e0 + int'(G);
    exp_s.push_back('{e0, model_mem[0]});
    exp_s.push_back('{e1, model_mem[1]});
    goto_neg(e1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("reset_mid");
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    last_s = cyc - 1;
    repeat (20) @(posedge clk);
    check_strobes("reset_mid_dump");
    @(negedge clk);
    chk("reset_mid_busy_after", busy, 0);
    chk("reset_mid_addr_after", ram_addr, 0);
    single_cmd(8'h50, 8'h70, 1'b0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
